pattern_gen: RTL and testbench
==============================

PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter C_x_bits, default 7, width of x coordinate (128 columns).
REQ-002 SHALL have parameter C_y_bits, default 8, width of y coordinate (256 rows addressable).
REQ-003 SHALL have parameter C_square_log2, default 3, checker square edge = 2^C_square_log2 pixels; legal 0..C_y_bits-1 and below C_x_bits.
REQ-004 SHALL have parameter C_scroll_step, default 1, x offset increment per frame when scrolling; width C_x_bits.
REQ-005 SHALL have parameter C_frame_bits, default 8, width of frame counter.
REQ-006 SHALL have ports: clki  in  1  system clock, rising edge.
REQ-007 resn  in  1  reset, asynchronous, active-low.
REQ-008 x  in  C_x_bits  column of requested pixel.
REQ-009 y  in  C_y_bits  row of requested pixel.
REQ-010 valid  in  1  x/y request strobe, one pixel per high cycle.
REQ-011 mode  in  2  requested pattern: 0 checker, 1 solid, 2 bars, 3 gradient.
REQ-012 mode_stb  in  1  capture mode into pending register.
REQ-013 scroll_en  in  1  enable per-frame horizontal scroll.
REQ-014 color_a, color_b  in  16 each  RGB565 colours for checker/solid.
REQ-015 color  out  16  RGB565 pixel, registered.
REQ-016 color_valid  out  1  color holds the pixel for the request one cycle earlier.
REQ-017 frame_start  out  1  one-cycle pulse aligned with color_valid of pixel (0,0).
REQ-018 frame_cnt  out  C_frame_bits  completed-frame count.

Function
REQ-019 Latency SHALL be exactly 1 cycle: request at cycle N -> color/color_valid at N+1; color_valid = valid delayed 1.
REQ-020 When valid low, color SHALL hold its last value; color_valid SHALL be 0.
REQ-021 Frame boundary = valid high with x==0 and y==0; only such requests SHALL update active mode, offset and frame_cnt.
REQ-022 mode_stb SHALL load pending_mode; last strobe before a boundary wins; mode_stb coincident with boundary SHALL take effect at that boundary.
REQ-023 At boundary, active_mode <= pending_mode and the boundary pixel itself SHALL use the new mode and new offset.
REQ-024 At boundary with scroll_en=1, offset <= offset + C_scroll_step modulo 2^C_x_bits; scroll_en=0 holds offset.
REQ-025 At boundary, frame_cnt SHALL increment, wrapping at 2^C_frame_bits to 0; the first boundary after reset yields frame_cnt 1.
REQ-026 xs = (x + offset) modulo 2^C_x_bits (offset applied before use in all modes).
REQ-027 Mode 0: color = xs[C_square_log2] ^ y[C_square_log2] ? color_a : color_b.
REQ-028 Mode 1: color = color_a.
REQ-029 Mode 2: bar index = xs[C_x_bits-1 -: 3]; palette 0..7 = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-030 Mode 3: color = {xs[C_x_bits-1 -: 5], y[C_y_bits-1 -: 6], 5'b0}; requires C_x_bits>=5, C_y_bits>=6.
REQ-031 color_a/color_b SHALL be sampled per pixel (no frame latching).

Reset
REQ-032 resn low SHALL asynchronously force color=0000, color_valid=0, frame_start=0, frame_cnt=0, offset=0, active_mode=0, pending_mode=0.
REQ-033 Release mid-frame SHALL apply mode 0, offset 0 until next boundary; outputs SHALL update from the first rising edge with resn high.

Verification
REQ-034 Reset, mode 0, color_a=07E0, color_b=F800, scan (0..127,0..15) -> (0,0)=F800, (8,0)=07E0, (8,8)=F800, each 1 cycle later, frame_start only at (0,0).
REQ-035 mode_stb with mode=2 mid-frame -> rest of frame stays checker; next (0,0)=FFFF, x=16 -> FFE0, x=127 -> 0000.
REQ-036 scroll_en=1, C_scroll_step=1, mode 2, 3 frames -> offset 1,2,3; frame 3 pixel x=13 -> FFE0 (xs=16); 128 frames -> offset wraps to 0.
REQ-037 Mode 3, request (127,255) -> F800|07E0 = FFE0; (0,0) -> 0000.
REQ-038 Run 256 frames, C_frame_bits=8 -> frame_cnt 255 then 0; valid gaps of 1..5 cycles -> color held, color_valid 0.
REQ-039 Assert resn mid-frame in mode 2 with offset 5 -> immediate outputs all zero; after release, next pixel uses checker with offset 0.

Source files
------------

// File: rtl/pattern_gen.sv
// Streaming test-pattern generator: one pixel per valid request, one cycle of latency.
// The mode and the scroll offset change only on the (0,0) pixel, which is also the frame boundary.
module pattern_gen #(
    parameter int                  C_x_bits      = 7,
    parameter int                  C_y_bits      = 8,
    parameter int                  C_square_log2 = 3,
    parameter logic [C_x_bits-1:0] C_scroll_step = {{(C_x_bits-1){1'b0}}, 1'b1},
    parameter int                  C_frame_bits  = 8
) (
    input  logic                    clki,
    input  logic                    resn,
    input  logic [C_x_bits-1:0]     x,
    input  logic [C_y_bits-1:0]     y,
    input  logic                    valid,
    input  logic [1:0]              mode,
    input  logic                    mode_stb,
    input  logic                    scroll_en,
    input  logic [15:0]             color_a,
    input  logic [15:0]             color_b,
    output logic [15:0]             color,
    output logic                    color_valid,
    output logic                    frame_start,
    output logic [C_frame_bits-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        MODE_CHECKER  = 2'd0,
        MODE_SOLID    = 2'd1,
        MODE_BARS     = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_t;

    mode_t                   pending_mode_q, pending_mode_d;
    mode_t                   active_mode_q, active_mode_d;
    logic [C_x_bits-1:0]     offset_q, offset_d;
    logic [C_frame_bits-1:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]             color_q, color_d;
    logic                    color_valid_q, color_valid_d;
    logic                    frame_start_q, frame_start_d;

    logic                    boundary;
    logic [C_x_bits-1:0]     xs;
    logic [15:0]             pixel;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    always_comb begin
        boundary       = valid && (x == '0) && (y == '0);
        pending_mode_d = mode_stb ? mode_t'(mode) : pending_mode_q;
        active_mode_d  = active_mode_q;
        offset_d       = offset_q;
        frame_cnt_d    = frame_cnt_q;

        // The boundary pixel already sees the new mode/offset, including a same-cycle strobe.
        if (boundary) begin
            active_mode_d = pending_mode_d;
            frame_cnt_d   = frame_cnt_q + C_frame_bits'(1);
            if (scroll_en) begin
                offset_d = offset_q + C_scroll_step;
            end
        end

        xs = x + offset_d;

        case (active_mode_d)
            MODE_CHECKER:  pixel = (xs[C_square_log2] ^ y[C_square_log2]) ? color_a : color_b;
            MODE_SOLID:    pixel = color_a;
            MODE_BARS:     pixel = bar_color(xs[C_x_bits-1 -: 3]);
            default:       pixel = {xs[C_x_bits-1 -: 5], y[C_y_bits-1 -: 6], 5'b0};
        endcase

        color_d       = valid ? pixel : color_q;
        color_valid_d = valid;
        frame_start_d = boundary;
    end

    always_ff @(posedge clki or negedge resn) begin
        if (!resn) begin
            pending_mode_q <= MODE_CHECKER;
            active_mode_q  <= MODE_CHECKER;
            offset_q       <= '0;
            frame_cnt_q    <= '0;
            color_q        <= 16'h0000;
            color_valid_q  <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            pending_mode_q <= pending_mode_d;
            active_mode_q  <= active_mode_d;
            offset_q       <= offset_d;
            frame_cnt_q    <= frame_cnt_d;
            color_q        <= color_d;
            color_valid_q  <= color_valid_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

    // Low coordinate bits only matter for some modes/parameterisations.
    logic unused_bits;
    assign unused_bits = ^{xs, y};

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: hand-derived vector table plus a queue scoreboard fed by a small reference model.
module tb_pattern_gen;

    logic        clki = 1'b0;
    logic        resn;
    logic [6:0]  x;
    logic [7:0]  y;
    logic        valid;
    logic [1:0]  mode;
    logic        mode_stb;
    logic        scroll_en;
    logic [15:0] color_a, color_b;
    logic [15:0] color;
    logic        color_valid;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    pattern_gen dut (
        .clki(clki), .resn(resn), .x(x), .y(y), .valid(valid),
        .mode(mode), .mode_stb(mode_stb), .scroll_en(scroll_en),
        .color_a(color_a), .color_b(color_b),
        .color(color), .color_valid(color_valid),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clki = ~clki;

    typedef struct {
        logic [15:0] color;
        logic        cv;
        logic        fs;
        logic [7:0]  fc;
    } exp_t;

    typedef struct {
        int          px;
        int          py;
        int          md;
        bit          stb;
        logic [15:0] exp_color;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    logic [1:0]  m_pend, m_act;
    logic [6:0]  m_off;
    logic [7:0]  m_fc;
    logic [15:0] m_col;

    function automatic logic [15:0] ref_pix(input logic [1:0] md, input int xs, input int yy,
                                            input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        int bar;
        bar = xs / 16;
        case (md)
            2'd0: r = ((((xs >> 3) & 1) ^ ((yy >> 3) & 1)) != 0) ? a : b;
            2'd1: r = a;
            2'd2: begin
                case (bar)
                    0: r = 16'hFFFF;  1: r = 16'hFFE0;  2: r = 16'h07FF;  3: r = 16'h07E0;
                    4: r = 16'hF81F;  5: r = 16'hF800;  6: r = 16'h001F;  default: r = 16'h0000;
                endcase
            end
            default: r = 16'(((xs >> 2) << 11) | ((yy >> 2) << 5));
        endcase
        return r;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 2'd0; m_act = 2'd0; m_off = 7'd0; m_fc = 8'd0; m_col = 16'h0000;
        sb.delete();
    endtask

    // Drive one request cycle, predict the result, then compare one cycle later.
    task automatic step(input int px, input int py, input bit v, input int md, input bit stb,
                        input bit scr, input bit use_tbl, input logic [15:0] tcol);
        exp_t e;
        exp_t got;
        bit   bnd;
        int   xs;
        x = 7'(px); y = 8'(py); valid = v; mode = 2'(md); mode_stb = stb; scroll_en = scr;
        if (stb) m_pend = 2'(md);
        bnd = v && (px == 0) && (py == 0);
        if (bnd) begin
            m_act = m_pend;
            m_fc  = m_fc + 8'd1;
            if (scr) m_off = m_off + 7'd1;
        end
        xs = (px + int'(m_off)) % 128;
        if (v) m_col = ref_pix(m_act, xs, py, color_a, color_b);
        e.color = use_tbl ? tcol : m_col;
        e.cv = v; e.fs = bnd; e.fc = m_fc;
        sb.push_back(e);
        @(posedge clki); #1;
        mode_stb = 1'b0;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            got = sb.pop_front();
            cmp($sformatf("color(%0d,%0d)", px, py), color, got.color);
            cmp("color_valid", {15'd0, color_valid}, {15'd0, got.cv});
            cmp("frame_start", {15'd0, frame_start}, {15'd0, got.fs});
            cmp("frame_cnt", {8'd0, frame_cnt}, {8'd0, got.fc});
            $display("req x=%0d y=%0d v=%0b -> color=%h cv=%0b fs=%0b fc=%0d",
                     px, py, v, color, color_valid, frame_start, frame_cnt);
        end
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, " color"}, color, 16'h0000);
        cmp({tag, " color_valid"}, {15'd0, color_valid}, 16'd0);
        cmp({tag, " frame_start"}, {15'd0, frame_start}, 16'd0);
        cmp({tag, " frame_cnt"}, {8'd0, frame_cnt}, 16'd0);
    endtask

    initial begin
        resn = 1'b0; x = '0; y = '0; valid = 1'b0; mode = 2'd0; mode_stb = 1'b0;
        scroll_en = 1'b0; color_a = 16'h07E0; color_b = 16'hF800;
        model_reset();

        // Hand-derived vectors: checker, deferred mode change, gradient, solid.
        tbl.push_back('{0,   0,   0, 0, 16'hF800});
        tbl.push_back('{8,   0,   0, 0, 16'h07E0});
        tbl.push_back('{8,   8,   0, 0, 16'hF800});
        tbl.push_back('{0,   8,   0, 0, 16'h07E0});
        tbl.push_back('{15,  0,   0, 0, 16'h07E0});
        tbl.push_back('{16,  0,   0, 0, 16'hF800});
        tbl.push_back('{20,  3,   2, 1, 16'hF800});
        tbl.push_back('{9,   1,   0, 0, 16'h07E0});
        tbl.push_back('{0,   0,   0, 0, 16'hFFFF});
        tbl.push_back('{16,  0,   0, 0, 16'hFFE0});
        tbl.push_back('{127, 0,   0, 0, 16'h0000});
        tbl.push_back('{64,  5,   0, 0, 16'hF81F});
        tbl.push_back('{0,   0,   3, 1, 16'h0000});
        tbl.push_back('{127, 255, 0, 0, 16'hFFE0});
        tbl.push_back('{64,  128, 0, 0, 16'h8400});
        tbl.push_back('{0,   0,   1, 1, 16'h07E0});
        tbl.push_back('{5,   5,   0, 0, 16'h07E0});

        repeat (3) @(posedge clki);
        #1 check_zero("reset");
        resn = 1'b1;

        foreach (tbl[i])
            step(tbl[i].px, tbl[i].py, 1'b1, tbl[i].md, tbl[i].stb, 1'b0, 1'b1, tbl[i].exp_color);

        // Checker scan of a small band, including a boundary
        for (int yy = 0; yy < 2; yy++)
            for (int xx = 0; xx < 20; xx++)
                step(xx, yy * 8, 1'b1, 0, (xx == 0 && yy == 0), 1'b0, 1'b0, 16'h0);

        // Scroll in bar mode: offsets 1,2,3, then x=13 lands on xs=16
        step(0, 0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 16'h0);
        step(0, 0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 16'h0);
        step(0, 0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 16'h0);
        step(13, 0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 16'hFFE0);
        step(12, 0, 1'b1, 2, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        for (int f = 0; f < 125; f++) step(0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 16'h0);
        // 128 scroll steps wrap the offset back to 0
        step(16, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 16'hFFE0);
        step(15, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 16'hFFFF);

        // Frame counter wrap
        for (int f = 0; f < 300 && m_fc != 8'd255; f++) step(0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        cmp("frame_cnt at 255", {8'd0, frame_cnt}, 16'd255);
        step(0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        cmp("frame_cnt wrapped", {8'd0, frame_cnt}, 16'd0);

        // Valid gaps with per-pixel colours and random coordinates
        for (int g = 1; g <= 5; g++) begin
            color_a = 16'($urandom); color_b = 16'($urandom);
            step(int'($urandom_range(1, 127)), int'($urandom_range(0, 255)), 1'b1, 0, 1'b0, 1'b0, 1'b0, 16'h0);
            for (int k = 0; k < g; k++) begin
                color_a = 16'($urandom);
                step(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)), 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
            end
        end

        // Mid-frame reset from bar mode with offset 5
        color_a = 16'h07E0; color_b = 16'hF800;
        step(0, 0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 16'h0);
        for (int f = 0; f < 4; f++) step(0, 0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 16'h0);
        step(3, 2, 1'b1, 0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        #2 resn = 1'b0;
        #1 check_zero("async reset");
        model_reset();
        #2 resn = 1'b1;
        step(3, 2, 1'b1, 0, 1'b0, 1'b0, 1'b1, 16'hF800);
        step(8, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 16'h07E0);
        step(0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 16'hF800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
